// File: rtl/grant_seq_pkg.sv
// Shared types and default sizes for the grant sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents: sequencer state enum, default requester count and counter width.
package grant_seq_pkg;

  // Two-state controller: waiting for a batch, or issuing grants from one.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Default number of requesters.
  localparam int GS_N    = 4;

  // Default width of the free-running completed-grant counter.
  localparam int GS_CNTW = 8;

endpackage

// File: rtl/highest_bit_clear.sv
// Finds the highest set bit of a vector and returns the vector with it cleared.
// Latency: purely combinational, zero cycles.
// Backpressure: n/a (no handshake).
//
// Ports:
//   vec     in   N     input bitmap
//   onehot  out  N     one-hot of highest set bit (0 when vec == 0)
//   idx     out  IDXW  binary index of that bit (0 when vec == 0)
//   cleared out  N     vec with its highest set bit removed
//   single  out  1     vec has exactly one bit set
module highest_bit_clear
  import grant_seq_pkg::*;
#(
  parameter int N    = GS_N,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    cleared,
  output logic            single
);

  // Ascending scan: each later set bit overwrites the earlier choice, so the
  // surviving selection is the highest set bit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDXW'(i);
      end
    end
  end

  assign cleared = vec & ~onehot;

  // Exactly one bit set <=> non-zero and nothing left once the top bit is gone.
  assign single  = (vec != '0) && (cleared == '0);

endmodule

// File: rtl/grant_sequencer.sv
// Issues one grant per handshake from a batch bitmap, highest index first.
// Latency: batch accepted at edge T, first grant visible in cycle T+1, one grant per cycle after.
// Backpressure: req_ready is low for the whole batch; grant outputs hold while grant_ready is low.
//
// Ports:
//   clk          in   1     clock, all state updates on rising edge
//   reset_n      in   1     synchronous active-low reset
//   req_valid    in   1     batch offered
//   req_ready    out  1     sequencer can accept a batch (IDLE)
//   req_vec      in   N     requester bitmap, bit i = requester i
//   grant_valid  out  1     grant presented (ISSUE)
//   grant_ready  in   1     consumer accepts current grant
//   grant        out  N     one-hot grant, zero when grant_valid is low
//   grant_idx    out  IDXW  binary index of granted requester
//   grant_last   out  1     current grant is the final one of the batch
//   flush        in   1     abandon remaining pending requests (ISSUE only)
//   busy         out  1     batch in progress
//   empty_batch  out  1     one-cycle pulse after an all-zero batch is accepted
//   grant_count  out  CNTW  completed grant handshakes, wraps
module grant_sequencer
  import grant_seq_pkg::*;
#(
  parameter int N    = GS_N,
  parameter int IDXW = $clog2(N),
  parameter int CNTW = GS_CNTW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_vec,
  output logic            grant_valid,
  input  logic            grant_ready,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_last,
  input  logic            flush,
  output logic            busy,
  output logic            empty_batch,
  output logic [CNTW-1:0] grant_count
);

  state_t          state;
  logic [N-1:0]    pending;

  logic [N-1:0]    top_onehot;
  logic [IDXW-1:0] top_idx;
  logic [N-1:0]    pending_next;
  logic            top_single;

  logic            issuing;
  logic            batch_take;
  logic            grant_take;

  highest_bit_clear #(
    .N    (N),
    .IDXW (IDXW)
  ) u_hbc (
    .vec     (pending),
    .onehot  (top_onehot),
    .idx     (top_idx),
    .cleared (pending_next),
    .single  (top_single)
  );

  assign issuing     = (state == ISSUE);

  assign req_ready   = ~issuing;
  assign busy        = issuing;
  assign grant_valid = issuing;

  // Outputs decode only from registered pending, so they cannot move while
  // the consumer stalls. Gating with issuing keeps them zero in IDLE.
  assign grant       = issuing ? top_onehot : '0;
  assign grant_idx   = issuing ? top_idx    : '0;
  assign grant_last  = issuing & top_single;

  assign batch_take  = req_valid & req_ready;
  assign grant_take  = grant_valid & grant_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= '0;
      grant_count <= '0;
      empty_batch <= 1'b0;
    end else begin
      empty_batch <= 1'b0;

      unique case (state)
        IDLE: begin
          // flush is deliberately ignored here; an offered batch proceeds.
          if (batch_take) begin
            if (req_vec != '0) begin
              pending <= req_vec;
              state   <= ISSUE;
            end else begin
              empty_batch <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (grant_take) begin
            pending     <= pending_next;
            grant_count <= grant_count + CNTW'(1);
            if (top_single) begin
              state <= IDLE;
            end
          end
          // flush wins over the pending update but the handshake above still
          // counts, because that grant was already delivered.
          if (flush) begin
            pending <= '0;
            state   <= IDLE;
          end
        end

        default: begin
          pending <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_sequencer.sv
module tb_grant_sequencer;

  localparam int N    = 4;
  localparam int IDXW = 2;
  localparam int CNTW = 8;
  localparam int VW   = 5 + N + IDXW + CNTW;

  logic            clk;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [N-1:0]    req_vec;
  logic            grant_valid;
  logic            grant_ready;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_last;
  logic            flush;
  logic            busy;
  logic            empty_batch;
  logic [CNTW-1:0] grant_count;

  int tests = 0;
  int fails = 0;

  // Reference model: pending requesters as a queue of indices in grant order,
  // an integer grant counter and the expected empty-batch pulse.
  int q[$];
  int exp_count = 0;
  bit exp_empty = 1'b0;

  grant_sequencer #(.N(N), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vec     (req_vec),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_last  (grant_last),
    .flush       (flush),
    .busy        (busy),
    .empty_batch (empty_batch),
    .grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] act_vec;
  assign act_vec = {req_ready, busy, grant_valid, grant, grant_idx,
                    grant_last, empty_batch, grant_count};

  // Expected full output vector from the model state.
  function automatic logic [VW-1:0] model_vec();
    logic            gv;
    logic [N-1:0]    g;
    logic [IDXW-1:0] gi;
    logic            gl;
    gv = (q.size() != 0);
    g  = '0;
    gi = '0;
    gl = 1'b0;
    if (gv) begin
      g[q[0]] = 1'b1;
      gi      = IDXW'(q[0]);
      gl      = (q.size() == 1);
    end
    return {~gv, gv, gv, g, gi, gl, exp_empty, CNTW'(exp_count)};
  endfunction

  // Apply the current inputs to the model, then move to 1 time unit after
  // the next rising edge, where outputs are sampled.
  task automatic advance();
    bit e_next;
    e_next = 1'b0;
    if (!reset_n) begin
      q.delete();
      exp_count = 0;
    end else if (q.size() == 0) begin
      if (req_valid) begin
        if (req_vec != '0) begin
          for (int i = N - 1; i >= 0; i--)
            if (req_vec[i]) q.push_back(i);
        end else begin
          e_next = 1'b1;
        end
      end
    end else begin
      if (grant_ready) begin
        void'(q.pop_front());
        exp_count = (exp_count + 1) % (1 << CNTW);
      end
      if (flush) q.delete();
    end
    @(posedge clk);
    #1;
    exp_empty = e_next;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_vec     = '0;
    grant_ready = 1'b0;
    flush       = 1'b0;
    advance();
    advance();
    tests++;
    if (act_vec !== {1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", act_vec,
               {1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0});
    end
    reset_n = 1'b1;
    advance();
  endtask

  task automatic test_basic_1011();
    logic [N-1:0]    tg [3];
    logic [IDXW-1:0] ti [3];
    logic            tl [3];
    int c0;
    tg = '{4'b1000, 4'b0010, 4'b0001};
    ti = '{2'd3, 2'd1, 2'd0};
    tl = '{1'b0, 1'b0, 1'b1};
    c0 = exp_count;
    req_valid = 1'b1; req_vec = 4'b1011; grant_ready = 1'b1;
    advance();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({grant_valid, busy, req_ready, grant, grant_idx, grant_last} !==
          {1'b1, 1'b1, 1'b0, tg[k], ti[k], tl[k]}) begin
        fails++;
        $display("FAIL basic_grant%0d: got g=%b idx=%0d last=%b vld=%b want g=%b idx=%0d last=%b",
                 k, grant, grant_idx, grant_last, grant_valid, tg[k], ti[k], tl[k]);
      end
      advance();
    end
    tests++;
    if (req_ready !== 1'b1 || grant_valid !== 1'b0 || grant_count !== CNTW'(c0 + 3)) begin
      fails++;
      $display("FAIL basic_done: got ready=%b vld=%b count=%0d want ready=1 vld=0 count=%0d",
               req_ready, grant_valid, grant_count, (c0 + 3) % 256);
    end
  endtask

  task automatic test_stall_0110();
    req_valid = 1'b1; req_vec = 4'b0110; grant_ready = 1'b0;
    advance();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      grant_ready = (k == 3);
      tests++;
      if ({grant_valid, grant, grant_idx, grant_last} !== {1'b1, 4'b0100, 2'd2, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold%0d: got g=%b idx=%0d last=%b want g=0100 idx=2 last=0",
                 k, grant, grant_idx, grant_last);
      end
      advance();
    end
    tests++;
    if ({grant_valid, grant, grant_idx, grant_last} !== {1'b1, 4'b0010, 2'd1, 1'b1}) begin
      fails++;
      $display("FAIL stall_second: got g=%b idx=%0d last=%b want g=0010 idx=1 last=1",
               grant, grant_idx, grant_last);
    end
    advance();
  endtask

  task automatic test_empty_batch();
    int c0;
    c0 = exp_count;
    req_valid = 1'b1; req_vec = 4'b0000;
    advance();
    req_valid = 1'b0;
    tests++;
    if ({empty_batch, grant_valid, busy, req_ready} !== 4'b1001) begin
      fails++;
      $display("FAIL empty_pulse: got empty=%b vld=%b busy=%b ready=%b want 1 0 0 1",
               empty_batch, grant_valid, busy, req_ready);
    end
    advance();
    tests++;
    if (empty_batch !== 1'b0 || grant_valid !== 1'b0 || grant_count !== CNTW'(c0)) begin
      fails++;
      $display("FAIL empty_after: got empty=%b vld=%b count=%0d want 0 0 %0d",
               empty_batch, grant_valid, grant_count, c0);
    end
  endtask

  task automatic test_flush();
    int c0;
    c0 = exp_count;
    req_valid = 1'b1; req_vec = 4'b1111; grant_ready = 1'b1;
    advance();
    req_valid = 1'b0;
    tests++;
    if (grant_idx !== 2'd3 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_first: got idx=%0d vld=%b want idx=3 vld=1", grant_idx, grant_valid);
    end
    advance();
    flush = 1'b1;
    tests++;
    if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_second: got idx=%0d vld=%b want idx=2 vld=1", grant_idx, grant_valid);
    end
    advance();
    flush = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000 ||
        grant_count !== CNTW'(c0 + 2)) begin
      fails++;
      $display("FAIL flush_idle: got ready=%b busy=%b g=%b count=%0d want 1 0 0000 %0d",
               req_ready, busy, grant, grant_count, (c0 + 2) % 256);
    end
    advance();
    tests++;
    if (grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_leftover: got vld=%b want 0", grant_valid);
    end
    // flush while idle must not block a simultaneous batch.
    flush = 1'b1; req_valid = 1'b1; req_vec = 4'b0101;
    advance();
    flush = 1'b0; req_valid = 1'b0;
    tests++;
    if (grant_valid !== 1'b1 || grant !== 4'b0100) begin
      fails++;
      $display("FAIL flush_in_idle: got vld=%b g=%b want 1 0100", grant_valid, grant);
    end
    advance();
    advance();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_vec = 4'b0011; grant_ready = 1'b0;
    advance();
    req_valid = 1'b0;
    tests++;
    if (grant_idx !== 2'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: got idx=%0d busy=%b want 1 1", grant_idx, busy);
    end
    reset_n = 1'b0;
    advance();
    reset_n = 1'b1;
    tests++;
    if (act_vec !== {1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL rstmid_post: got %h want %h", act_vec,
               {1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0});
    end
    grant_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int k;
    // Start from a known zero count.
    reset_n = 1'b0;
    advance();
    reset_n = 1'b1;
    grant_ready = 1'b1;
    // 63 batches of four plus one of three: 255 handshakes.
    for (int b = 0; b < 64; b++) begin
      req_valid = 1'b1;
      req_vec   = (b < 63) ? 4'b1111 : 4'b0111;
      k         = (b < 63) ? 4 : 3;
      advance();
      req_valid = 1'b0;
      for (int j = 0; j < k; j++) advance();
    end
    tests++;
    if (grant_count !== 8'd255) begin
      fails++;
      $display("FAIL wrap_255: got count=%0d want 255", grant_count);
    end
    req_valid = 1'b1; req_vec = 4'b0001;
    advance();
    req_valid = 1'b0;
    advance();
    tests++;
    if (grant_count !== 8'd0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL wrap_zero: got count=%0d ready=%b want 0 1", grant_count, req_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tests++;
      if (act_vec !== model_vec()) begin
        fails++;
        $display("FAIL random_c%0d: got %h want %h", c, act_vec, model_vec());
      end
      reset_n     = ($urandom_range(0, 79) != 0);
      req_valid   = ($urandom_range(0, 2) != 0);
      req_vec     = N'($urandom_range(0, 15));
      grant_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 11) == 0);
      advance();
    end
    reset_n = 1'b1; req_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_1011();
    test_stall_0110();
    test_empty_batch();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
